// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between two one-entry frame slots,
// with a completion watchdog that drops a frame if tx_done never arrives.
module tx_arbiter #(
    parameter int FRAME_W = 9,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [FRAME_W-1:0] req0_frame,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [FRAME_W-1:0] req1_frame,
    output logic               req1_ready,
    input  logic               tx_done,
    input  logic               err_clr,
    output logic               send,
    output logic [FRAME_W-1:0] frame_out,
    output logic               grant_id,
    output logic               busy,
    output logic               timeout_err
);

    // state | meaning
    // IDLE  | no transfer in flight; picks a full slot (round-robin on a tie)
    // SEND  | one-cycle send strobe to the UART
    // WAIT  | waiting for tx_done, watchdog running
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [1:0]         slot_full_q, slot_full_d;
    logic [FRAME_W-1:0] slot0_frame_q, slot0_frame_d;
    logic [FRAME_W-1:0] slot1_frame_q, slot1_frame_d;
    logic [FRAME_W-1:0] frame_out_q, frame_out_d;
    logic               grant_id_q, grant_id_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic               timeout_err_q, timeout_err_d;
    logic               send_q, send_d;
    logic               busy_q, busy_d;

    logic               acc0, acc1;
    logic               free_slot;
    logic               fire_timeout;
    logic               winner;

    always_comb begin
        state_d       = state_q;
        frame_out_d   = frame_out_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        wdog_d        = wdog_q;
        slot0_frame_d = slot0_frame_q;
        slot1_frame_d = slot1_frame_q;
        free_slot     = 1'b0;
        fire_timeout  = 1'b0;
        winner        = 1'b0;

        acc0 = req0_valid & ~slot_full_q[0];
        acc1 = req1_valid & ~slot_full_q[1];

        case (state_q)
            ST_IDLE: begin
                if (|slot_full_q) begin
                    // On a tie the requester not served last wins
                    winner      = (&slot_full_q) ? ~last_grant_q : slot_full_q[1];
                    grant_id_d  = winner;
                    frame_out_d = winner ? slot1_frame_q : slot0_frame_q;
                    wdog_d      = '0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    free_slot    = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    free_slot    = 1'b1;
                    fire_timeout = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        slot_full_d[0] = (slot_full_q[0] & ~(free_slot & ~grant_id_q)) | acc0;
        slot_full_d[1] = (slot_full_q[1] & ~(free_slot &  grant_id_q)) | acc1;
        if (acc0) slot0_frame_d = req0_frame;
        if (acc1) slot1_frame_d = req1_frame;

        if (fire_timeout)   timeout_err_d = 1'b1;
        else if (err_clr)   timeout_err_d = 1'b0;
        else                timeout_err_d = timeout_err_q;

        send_d = (state_d == ST_SEND);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            slot_full_q   <= 2'b00;
            slot0_frame_q <= '0;
            slot1_frame_q <= '0;
            frame_out_q   <= '0;
            grant_id_q    <= 1'b0;
            last_grant_q  <= 1'b1;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            send_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_full_q   <= slot_full_d;
            slot0_frame_q <= slot0_frame_d;
            slot1_frame_q <= slot1_frame_d;
            frame_out_q   <= frame_out_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            send_q        <= send_d;
            busy_q        <= busy_d;
        end
    end

    assign req0_ready  = ~slot_full_q[0];
    assign req1_ready  = ~slot_full_q[1];
    assign send        = send_q;
    assign frame_out   = frame_out_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: cycle vector table, randomized run against a slot/transfer model,
// and directed sequences for simultaneous requests, fairness, watchdog and mid-transfer reset.
module tb_tx_arbiter;

    localparam int FW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [FW-1:0] req0_frame = '0, req1_frame = '0;
    logic          req0_ready, req1_ready;
    logic          tx_done = 1'b0, err_clr = 1'b0;
    logic          send, grant_id, busy, timeout_err;
    logic [FW-1:0] frame_out;

    int n_pass  = 0;
    int n_total = 0;

    tx_arbiter #(.FRAME_W(FW), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_frame(req0_frame), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_frame(req1_frame), .req1_ready(req1_ready),
        .tx_done(tx_done), .err_clr(err_clr),
        .send(send), .frame_out(frame_out), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v0;
        logic [FW-1:0] f0;
        logic          v1;
        logic [FW-1:0] f1;
        logic          done;
        logic          clr;
        logic          e_send;
        logic [FW-1:0] e_frame;
        logic          e_gid;
        logic          e_busy;
        logic          e_r0;
        logic          e_r1;
        logic          e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, send, frame_out, grant_id, busy, req0_ready, req1_ready, timeout_err};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tx_done = 1'b0; err_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_send();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!send && n < 50);
        chk("send_seen", {31'd0, send}, 32'd1);
    endtask

    task automatic load_both(input logic [FW-1:0] a, input logic [FW-1:0] b);
        req0_valid = 1'b1; req0_frame = a;
        req1_valid = 1'b1; req1_frame = b;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Randomized run: model tracks slot occupancy and the in-flight transfer phase
    task automatic random_run(input int cycles);
        bit          pend[2];
        logic [FW-1:0] pfrm[2];
        bit          last, egid, esend, w, acc0, acc1;
        logic [FW-1:0] efrm;
        int          stage, wcnt, dly;
        pend = '{0, 0}; pfrm = '{'0, '0};
        last = 1'b1; egid = 1'b0; efrm = '0; stage = 0; wcnt = 0; dly = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_frame = FW'($urandom);
            req1_frame = FW'($urandom);
            if (stage == 2) tx_done = (wcnt == dly);
            else            tx_done = ($urandom_range(0, 7) == 0);

            acc0 = req0_valid & !pend[0];
            acc1 = req1_valid & !pend[1];
            esend = 1'b0;
            case (stage)
                0: if (pend[0] | pend[1]) begin
                    w = (pend[0] & pend[1]) ? !last : pend[1];
                    egid = w; efrm = pfrm[w]; esend = 1'b1; stage = 1;
                end
                1: begin stage = 2; wcnt = 0; dly = $urandom_range(0, 5); end
                default: if (tx_done) begin
                    pend[egid] = 0; last = egid; stage = 0;
                end else wcnt++;
            endcase
            if (acc0) begin pend[0] = 1; pfrm[0] = req0_frame; end
            if (acc1) begin pend[1] = 1; pfrm[1] = req1_frame; end

            tick();
            chk("random", outs(),
                {17'd0, esend, efrm, egid, (stage != 0), !pend[0], !pend[1], 1'b0});
        end
        req0_valid = 1'b0; req1_valid = 1'b0; tx_done = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 9'h0A5, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = vecs[2];
        vecs[6]  = vecs[2];
        vecs[7]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 9'h000, 1'b1, 9'h133, 1'b1, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h133, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h133, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h133, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h133, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        tick();
        do_reset();
        #1;
        chk("reset_state", outs(), {17'd0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

        // Single transfer, then tx_done in IDLE / SEND ignored
        for (int i = 0; i < 13; i++) begin
            req0_valid = vecs[i].v0; req0_frame = vecs[i].f0;
            req1_valid = vecs[i].v1; req1_frame = vecs[i].f1;
            tx_done = vecs[i].done;  err_clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {17'd0, vecs[i].e_send, vecs[i].e_frame, vecs[i].e_gid, vecs[i].e_busy,
                 vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_err});
        end
        req0_valid = 1'b0; req1_valid = 1'b0; tx_done = 1'b0;

        // Simultaneous accept: req0 first, req1 exactly two cycles after tx_done
        do_reset();
        load_both(9'h011, 9'h122);
        wait_send();
        chk("sim_first", {22'd0, frame_out, grant_id}, {22'd0, 9'h011, 1'b0});
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("sim_gap", {31'd0, send}, 32'd0);
        tick();
        chk("sim_second", {21'd0, send, frame_out, grant_id}, {21'd0, 1'b1, 9'h122, 1'b1});

        // Fairness with both requesters refilling continuously
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_frame = FW'(9'h040 + i);
            req1_frame = FW'(9'h140 + i);
            wait_send();
            chk($sformatf("fair_gid%0d", i), {31'd0, grant_id}, 32'(i % 2));
            tick();
            chk($sformatf("send_width%0d", i), {31'd0, send}, 32'd0);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Watchdog: timeout, slot freed, pending req1 served, err sticky until err_clr
        do_reset();
        load_both(9'h044, 9'h155);
        wait_send();
        chk("wd_first_gid", {31'd0, grant_id}, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("wd_err_before", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("wd_err_set", {28'd0, timeout_err, req0_ready, req1_ready, busy}, {28'd0, 4'b1100});
        tick();
        chk("wd_next_grant", {21'd0, send, frame_out, grant_id}, {21'd0, 1'b1, 9'h155, 1'b1});
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("wd_sticky", {30'd0, timeout_err, req1_ready}, {30'd0, 2'b11});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_err_clr", {31'd0, timeout_err}, 32'd0);

        // Reset mid-WAIT discards slots; later tx_done has no effect
        do_reset();
        load_both(9'h066, 9'h177);
        wait_send();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_wait", {27'd0, req0_ready, req1_ready, busy, timeout_err, send}, {27'd0, 5'b11000});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("rst_stray_done", {27'd0, req0_ready, req1_ready, busy, timeout_err, send}, {27'd0, 5'b11000});

        random_run(400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single UART transmit path between two frame sources: the switch-driven frame input (requester 0) and clock/config readback responses (requester 1).
- Each requester has a one-entry holding slot. Slots are granted round-robin.
- Drives the UART's send strobe and 9-bit transmit frame, and waits for transmit completion before the next grant.
- A watchdog recovers from a missing completion.

Parameters:
- FRAME_W, 9: frame width in bits.
- TIMEOUT, 4096: clk cycles to wait in WAIT for tx_done before aborting; minimum 2.
- CNT_W, 13: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 offers a frame.
- req0_frame  in  FRAME_W  requester 0 frame.
- req0_ready  out  1  requester 0 slot empty.
- req1_valid  in  1  requester 1 offers a frame.
- req1_frame  in  FRAME_W  requester 1 frame.
- req1_ready  out  1  requester 1 slot empty.
- tx_done  in  1  one-cycle pulse from the UART: frame fully shifted out.
- err_clr  in  1  clears timeout_err.
- send  out  1  one-cycle transmit strobe to the UART.
- frame_out  out  FRAME_W  frame to transmit, stable from the send cycle through the end of WAIT.
- grant_id  out  1  requester currently or last granted.
- busy  out  1  high in SEND or WAIT.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:

Slots
- reqN_ready = ~slotN_full (registered state).
- Handshake fires when reqN_valid & reqN_ready at a rising edge. The frame is captured and slotN_full = 1 from the next cycle.
- Both requesters may be accepted in the same cycle.
- valid while not ready: no effect. The requester must hold its frame.

States: IDLE, SEND, WAIT.

IDLE
- If neither slot is full: stay in IDLE.
- If exactly one slot is full: grant it.
- If both are full: grant the requester != last_grant.
- On grant: frame_out <= slot frame, grant_id <= winner, watchdog cleared, next state SEND.

SEND
- send = 1 for exactly this one cycle. Next state WAIT.

WAIT
- Watchdog increments every cycle.
- On tx_done: free the granted slot (ready rises the next cycle), last_grant <= grant_id, next state IDLE.
- If the watchdog reaches TIMEOUT-1 with no tx_done: free the slot (frame dropped), set timeout_err, update last_grant, next state IDLE.
- tx_done and timeout in the same cycle: treated as normal completion; timeout_err is not set.

Latency
- Handshake at cycle 0 → slot full at cycle 1 → send = 1 at cycle 2 when the arbiter was idle.
- After tx_done at cycle T, the next grant's send occurs at T+2.

Ignored or fixed-priority events
- tx_done outside WAIT is ignored.
- A requester whose slot is being freed cannot be accepted in the tx_done cycle (its ready is still 0).
- timeout_err: set has priority over err_clr in the same cycle. Otherwise err_clr clears it.

Reset (synchronous)
- state = IDLE, both slots empty (req0_ready = req1_ready = 1).
- send = 0, busy = 0, frame_out = 0, grant_id = 0, timeout_err = 0, watchdog = 0.
- last_grant = 1, so requester 0 wins the first tie.
- Reset during SEND or WAIT discards both slots and any pending tx_done.

Outputs
- busy = (state != IDLE), registered.
- frame_out and grant_id hold their last values while in IDLE.

Test Plan:
1. Reset, then a req0 handshake with frame 9'h0A5 at cycle 0 → req0_ready = 0 from cycle 1; send = 1 only at cycle 2 with frame_out = 9'h0A5, grant_id = 0; tx_done 5 cycles later → req0_ready = 1 the next cycle, busy = 0.
2. req0 (9'h011) and req1 (9'h122) accepted in the same cycle after reset → 9'h011 sent first; after its tx_done, 9'h122 is sent exactly 2 cycles later with grant_id = 1.
3. Fairness: keep both requesters refilling immediately for 6 transmissions → grant_id sequence 0,1,0,1,0,1; no send pulse is ever longer than 1 cycle.
4. TIMEOUT = 8, tx_done never asserted → timeout_err rises 8 cycles after entering WAIT; slot freed; pending req1 granted next. err_clr pulse → timeout_err = 0.
5. Assert rst mid-WAIT with req1 slot full → next cycle both ready = 1, busy = 0, timeout_err = 0; a later tx_done pulse produces no slot change.
6. tx_done pulses in IDLE and in the SEND cycle → ignored; the transaction completes only on a tx_done received in WAIT.
